dpram_port_a_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the read/write port A of the 512x8 dual-port RAM. It serialises single-word read and write commands from two masters onto port A, generates the RAM chip-select and write-enable, and returns read data with a valid strobe. Port B (read-only) is wired directly to its consumer. This block only keeps chip-select asserted so that port B keeps reading.

---
 rtl/dpram_arb_pkg.sv | 13 +
 rtl/dpram_port_a_arbiter_if.sv | 35 +++
 rtl/dpram_port_a_arbiter_rr_arb2.sv | 16 +
 rtl/dpram_port_a_arbiter.sv | 113 +++++++++++
 tb/tb_dpram_port_a_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and default widths for the port A arbiter of the 512x8 dual-port RAM.
package dpram_arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dpram_port_a_arbiter_if.sv
// Single-word command bus between one master and the port A arbiter.
interface dpram_port_a_arbiter_if #(
    parameter int ADDR_W = dpram_arb_pkg::ADDR_W,
    parameter int DATA_W = dpram_arb_pkg::DATA_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/dpram_port_a_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; the last-grant pointer lives in the caller.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    // last_gnt = 1 means master 1 won last, so master 0 takes the tie.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_gnt ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dpram_port_a_arbiter.sv
// Serialises single-word commands from two masters onto RAM port A and keeps chip-select up for port B.
module dpram_port_a_arbiter #(
    parameter int ADDR_W = dpram_arb_pkg::ADDR_W,
    parameter int DATA_W = dpram_arb_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dpram_port_a_arbiter_if.slave m0,
    dpram_port_a_arbiter_if.slave m1,
    output logic                  ram_cs,
    output logic                  ram_we_a,
    output logic [ADDR_W-1:0]     ram_addr_a,
    output logic [DATA_W-1:0]     ram_data_in_a,
    input  logic [DATA_W-1:0]     ram_data_out_a
);

    import dpram_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        win;

    rr_arb2 u_rr_arb2 (
        .req      ({m1.req, m0.req}),
        .last_gnt (last_q),
        .gnt      (win)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        cs_d     = 1'b1;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (win != 2'b00) begin
                    owner_d = win[1];
                    last_d  = win[1];
                    gnt_d   = win;
                    we_d    = win[1] ? m1.we    : m0.we;
                    addr_d  = win[1] ? m1.addr  : m0.addr;
                    wdata_d = win[1] ? m1.wdata : m0.wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The RAM captures the command on this edge; reads owe a valid strobe next cycle.
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    rvalid_d = owner_q ? 2'b10 : 2'b01;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cs_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cs_q     <= cs_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ram_cs        = cs_q;
    assign ram_we_a      = we_q;
    assign ram_addr_a    = addr_q;
    assign ram_data_in_a = wdata_q;

    assign m0.gnt    = gnt_q[0];
    assign m0.rvalid = rvalid_q[0];
    assign m0.rdata  = ram_data_out_a;
    assign m1.gnt    = gnt_q[1];
    assign m1.rvalid = rvalid_q[1];
    assign m1.rdata  = ram_data_out_a;

endmodule

// File: tb/tb_dpram_port_a_arbiter.sv
// Randomised bench for dpram_port_a_arbiter against a transaction-level model of the arbiter and RAM.
`timescale 1ns/1ps
module tb_dpram_port_a_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_cs;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_in_a;
    logic [DW-1:0] ram_data_out_a = '0;
    logic [DW-1:0] ram_mem [0:511] = '{default: 8'h00};

    dpram_port_a_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
    dpram_port_a_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

    dpram_port_a_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_cs         (ram_cs),
        .ram_we_a       (ram_we_a),
        .ram_addr_a     (ram_addr_a),
        .ram_data_in_a  (ram_data_in_a),
        .ram_data_out_a (ram_data_out_a)
    );

    always #5 clk = ~clk;

    // External RAM: registered read-first port A, active only while chip-select is up.
    always @(posedge clk) begin
        if (ram_cs) begin
            ram_data_out_a <= ram_mem[ram_addr_a];
            if (ram_we_a) ram_mem[ram_addr_a] <= ram_data_in_a;
        end
    end

    int checkCount = 0;
    int errCount = 0;
    bit holdRst = 1'b1;
    cmd_t q0[$];
    cmd_t q1[$];

    // Reference model: memory contents, who may be granted next, and which edge frees the port.
    logic [DW-1:0] refMem [0:511] = '{default: 8'h00};
    int            cyc = 0;
    int            nextFree = 0;
    bit            refLast = 1'b1;
    bit            pendWrite = 1'b0;
    bit            pendRead = 1'b0;
    bit            pendOwner = 1'b0;
    logic [AW-1:0] pendAddr = '0;
    logic [DW-1:0] pendData = '0;
    bit [1:0]      expGnt;
    bit [1:0]      expRv;
    bit            expWe;
    bit            expCs;
    bit            expZero;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    logic [DW-1:0] expRdata;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, actual, expected);
        end
    endtask

    task automatic pushCmd(input int m, input bit we, input int addr, input int data);
        cmd_t c;
        c.we   = we;
        c.addr = addr[AW-1:0];
        c.data = data[DW-1:0];
        if (m == 0) q0.push_back(c);
        else        q1.push_back(c);
    endtask

    task automatic applyStimulus();
        if (q0.size() > 0) begin
            m0_bus.req = 1'b1; m0_bus.we = q0[0].we; m0_bus.addr = q0[0].addr; m0_bus.wdata = q0[0].data;
        end else begin
            m0_bus.req = 1'b0; m0_bus.we = 1'($urandom); m0_bus.addr = AW'($urandom); m0_bus.wdata = DW'($urandom);
        end
        if (q1.size() > 0) begin
            m1_bus.req = 1'b1; m1_bus.we = q1[0].we; m1_bus.addr = q1[0].addr; m1_bus.wdata = q1[0].data;
        end else begin
            m1_bus.req = 1'b0; m1_bus.we = 1'($urandom); m1_bus.addr = AW'($urandom); m1_bus.wdata = DW'($urandom);
        end
    endtask

    task automatic resetModel();
        pendWrite = 1'b0;
        pendRead  = 1'b0;
        refLast   = 1'b1;
        nextFree  = cyc + 1;
        expGnt    = 2'b00;
        expRv     = 2'b00;
        expWe     = 1'b0;
        expCs     = 1'b0;
        expZero   = 1'b1;
    endtask

    // One clock edge of the abstract arbiter: retire the previous command, then maybe grant a new one.
    task automatic modelEdge();
        bit   win;
        cmd_t c;
        expGnt  = 2'b00;
        expRv   = 2'b00;
        expWe   = 1'b0;
        expZero = 1'b0;
        if (!rst_n) begin
            resetModel();
            return;
        end
        expCs = 1'b1;
        if (pendWrite) refMem[pendAddr] = pendData;
        pendWrite = 1'b0;
        if (pendRead) begin
            expRv[pendOwner] = 1'b1;
            expRdata = refMem[pendAddr];
        end
        pendRead = 1'b0;
        if (cyc >= nextFree && (m0_bus.req || m1_bus.req)) begin
            if (m0_bus.req && m1_bus.req) win = ~refLast;
            else                          win = m1_bus.req;
            c.we   = win ? m1_bus.we    : m0_bus.we;
            c.addr = win ? m1_bus.addr  : m0_bus.addr;
            c.data = win ? m1_bus.wdata : m0_bus.wdata;
            refLast     = win;
            expGnt[win] = 1'b1;
            expAddr     = c.addr;
            pendAddr    = c.addr;
            if (c.we) begin
                expWe     = 1'b1;
                expWdata  = c.data;
                pendData  = c.data;
                pendWrite = 1'b1;
                nextFree  = cyc + 2;
            end else begin
                pendRead  = 1'b1;
                pendOwner = win;
                nextFree  = cyc + 3;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("m0_gnt", 32'(m0_bus.gnt), 32'(expGnt[0]));
        checkOutput("m1_gnt", 32'(m1_bus.gnt), 32'(expGnt[1]));
        checkOutput("m0_rvalid", 32'(m0_bus.rvalid), 32'(expRv[0]));
        checkOutput("m1_rvalid", 32'(m1_bus.rvalid), 32'(expRv[1]));
        checkOutput("ram_we_a", 32'(ram_we_a), 32'(expWe));
        checkOutput("ram_cs", 32'(ram_cs), 32'(expCs));
        if (expRv[0]) checkOutput("m0_rdata", 32'(m0_bus.rdata), 32'(expRdata));
        if (expRv[1]) checkOutput("m1_rdata", 32'(m1_bus.rdata), 32'(expRdata));
        if (expGnt != 2'b00) checkOutput("ram_addr_a", 32'(ram_addr_a), 32'(expAddr));
        if (expWe) checkOutput("ram_data_in_a", 32'(ram_data_in_a), 32'(expWdata));
        if (expZero) begin
            checkOutput("rst_addr", 32'(ram_addr_a), 32'h0);
            checkOutput("rst_wdata", 32'(ram_data_in_a), 32'h0);
        end
    endtask

    // Drive at the falling edge, model the rising edge, sample 2 ns later; optionally pulse reset mid-cycle.
    task automatic stepCycle(input bit pulseReset);
        @(negedge clk);
        rst_n = !holdRst;
        applyStimulus();
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
        if (pulseReset) begin
            rst_n = 1'b0;
            resetModel();
        end
        #1;
        checkAll();
        if (m0_bus.gnt && q0.size() > 0) void'(q0.pop_front());
        if (m1_bus.gnt && q1.size() > 0) void'(q1.pop_front());
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            stepCycle(1'b0);
            n++;
        end
        checkOutput("drain_timeout", 32'(q0.size() + q1.size()), 32'h0);
        for (int i = 0; i < 4; i++) stepCycle(1'b0);
    endtask

    initial begin
        int n;
        applyStimulus();

        $display("[TB] reset and chip-select release");
        for (int i = 0; i < 3; i++) stepCycle(1'b0);
        holdRst = 1'b0;
        for (int i = 0; i < 3; i++) stepCycle(1'b0);
        stepCycle(1'b1);
        for (int i = 0; i < 2; i++) stepCycle(1'b0);

        $display("[TB] m0 write then read-back at 0x1A5");
        pushCmd(0, 1'b1, 'h1A5, 'h3C);
        pushCmd(0, 1'b0, 'h1A5, 'h00);
        drain(40);

        $display("[TB] both masters streaming writes to 0x000 and 0x1FF");
        for (int i = 0; i < 4; i++) begin
            pushCmd(0, 1'b1, 'h000, 'h10 + i);
            pushCmd(1, 1'b1, 'h1FF, 'hA0 + i);
        end
        pushCmd(0, 1'b0, 'h000, 'h00);
        pushCmd(1, 1'b0, 'h1FF, 'h00);
        drain(80);

        $display("[TB] tie after m0 was granted last: m1 write 0x010 vs m0 read 0x010");
        pushCmd(0, 1'b1, 'h020, 'h77);
        drain(20);
        pushCmd(1, 1'b1, 'h010, 'h55);
        pushCmd(0, 1'b0, 'h010, 'h00);
        drain(40);

        $display("[TB] lone m1 read at 0x1FF");
        pushCmd(1, 1'b0, 'h1FF, 'h00);
        drain(20);

        $display("[TB] reset pulse during RESP of an m1 read");
        pushCmd(1, 1'b0, 'h1FF, 'h00);
        n = 0;
        while (q1.size() > 0 && n < 20) begin
            stepCycle(1'b0);
            n++;
        end
        checkOutput("m1_gnt_timeout", 32'(q1.size()), 32'h0);
        stepCycle(1'b1);
        stepCycle(1'b0);
        pushCmd(0, 1'b1, 'h033, 'h5A);
        pushCmd(1, 1'b1, 'h044, 'hA5);
        drain(40);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 600; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0)
                pushCmd(0, 1'($urandom), ($urandom_range(0, 1) == 0) ? 'h1FF : int'($urandom_range(0, 7)), int'($urandom));
            if (q1.size() == 0 && $urandom_range(0, 2) == 0)
                pushCmd(1, 1'($urandom), ($urandom_range(0, 1) == 0) ? 'h1FF : int'($urandom_range(0, 7)), int'($urandom));
            stepCycle(1'b0);
        end
        drain(40);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
